// File: rtl/dm_load_stage.sv
// Memory-stage load formatting and the M->W pipeline register.
// Decodes the load type, aligns and extends the data, and flags address errors.
module dm_load_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_M,
    input  logic [2:0]  loadop_M,
    input  logic [31:0] data_alu_M,
    input  logic [31:0] data_dm_M,
    input  logic [31:0] pcout_M,
    input  logic [4:0]  regaddr_M,
    input  logic        stall,
    input  logic        flush,
    output logic        load_W,
    output logic [31:0] data_load_W,
    output logic [4:0]  regaddr_W,
    output logic [31:0] pcout_W,
    output logic        adel_W,
    output logic [31:0] badaddr_W
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;

    logic        w_valid_op;
    logic        w_misalign;
    logic        w_oor;
    logic        w_err;
    logic        w_wr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_data;

    logic        r_load;
    logic [31:0] r_data;
    logic [4:0]  r_regaddr;
    logic [31:0] r_pc;
    logic        r_adel;
    logic [31:0] r_badaddr;

    always_comb begin
        w_byte = data_dm_M[7:0];
        case (data_alu_M[1:0])
            2'd0:    w_byte = data_dm_M[7:0];
            2'd1:    w_byte = data_dm_M[15:8];
            2'd2:    w_byte = data_dm_M[23:16];
            default: w_byte = data_dm_M[31:24];
        endcase
        // Odd halfword offsets are misaligned, so only bit 1 picks the lane.
        w_half = data_alu_M[1] ? data_dm_M[31:16] : data_dm_M[15:0];

        w_valid_op = (loadop_M <= OP_LBU);
        w_misalign = 1'b0;
        case (loadop_M)
            OP_LW:         w_misalign = (data_alu_M[1:0] != 2'b00);
            OP_LH, OP_LHU: w_misalign = data_alu_M[0];
            default:       w_misalign = 1'b0;
        endcase
        w_oor = |data_alu_M[31:12];

        w_err = load_M & w_valid_op & (w_misalign | w_oor);
        w_wr  = load_M & w_valid_op & ~w_err & (regaddr_M != 5'd0);

        w_data = '0;
        if (w_wr) begin
            case (loadop_M)
                OP_LW:   w_data = data_dm_M;
                OP_LH:   w_data = {{16{w_half[15]}}, w_half};
                OP_LHU:  w_data = {16'h0000, w_half};
                OP_LB:   w_data = {{24{w_byte[7]}}, w_byte};
                OP_LBU:  w_data = {24'h000000, w_byte};
                default: w_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_load    <= 1'b0;
            r_data    <= '0;
            r_regaddr <= '0;
            r_pc      <= '0;
            r_adel    <= 1'b0;
            r_badaddr <= '0;
        end else if (!stall) begin
            r_load    <= w_wr;
            r_data    <= w_data;
            r_regaddr <= regaddr_M;
            r_pc      <= pcout_M;
            r_adel    <= w_err;
            r_badaddr <= w_err ? data_alu_M : '0;
        end
    end

    assign load_W      = r_load;
    assign data_load_W = r_data;
    assign regaddr_W   = r_regaddr;
    assign pcout_W     = r_pc;
    assign adel_W      = r_adel;
    assign badaddr_W   = r_badaddr;

endmodule

// File: tb/tb_dm_load_stage.sv
// Table-driven bench for dm_load_stage: each row drives one cycle of M inputs
// and queues the hand-derived W outputs expected after the next rising edge.
module tb_dm_load_stage;

    logic        clk;
    logic        reset;
    logic        load_M;
    logic [2:0]  loadop_M;
    logic [31:0] data_alu_M;
    logic [31:0] data_dm_M;
    logic [31:0] pcout_M;
    logic [4:0]  regaddr_M;
    logic        stall;
    logic        flush;
    logic        load_W;
    logic [31:0] data_load_W;
    logic [4:0]  regaddr_W;
    logic [31:0] pcout_W;
    logic        adel_W;
    logic [31:0] badaddr_W;

    dm_load_stage dut (
        .clk         (clk),
        .reset       (reset),
        .load_M      (load_M),
        .loadop_M    (loadop_M),
        .data_alu_M  (data_alu_M),
        .data_dm_M   (data_dm_M),
        .pcout_M     (pcout_M),
        .regaddr_M   (regaddr_M),
        .stall       (stall),
        .flush       (flush),
        .load_W      (load_W),
        .data_load_W (data_load_W),
        .regaddr_W   (regaddr_W),
        .pcout_W     (pcout_W),
        .adel_W      (adel_W),
        .badaddr_W   (badaddr_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        adel;
        logic [31:0] bad;
    } out_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        stl;
        logic        fl;
        logic        ld;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] dm;
        logic [31:0] pc;
        logic [4:0]  rd;
        out_t        exp;
    } vec_t;

    vec_t vt[$];
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic out_t mk(input logic l, input logic [31:0] d, input logic [4:0] r,
                                input logic [31:0] p, input logic a, input logic [31:0] b);
        out_t o;
        o.load = l; o.data = d; o.rd = r; o.pc = p; o.adel = a; o.bad = b;
        return o;
    endfunction

    task automatic add(input string nm, input logic rs, input logic st, input logic f,
                       input logic l, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] p, input logic [4:0] r,
                       input out_t e);
        vec_t v;
        v.name = nm; v.rst = rs; v.stl = st; v.fl = f; v.ld = l; v.op = op;
        v.addr = a; v.dm = d; v.pc = p; v.rd = r; v.exp = e;
        vt.push_back(v);
    endtask

    task automatic check(input string nm);
        out_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, no expected value", nm);
            return;
        end
        e = exp_q.pop_front();
        if (load_W !== e.load || data_load_W !== e.data || regaddr_W !== e.rd ||
            pcout_W !== e.pc || adel_W !== e.adel || badaddr_W !== e.bad) begin
            n_fail++;
            $display("FAIL %s: got ld=%b d=%h rd=%0d pc=%h adel=%b bad=%h, exp ld=%b d=%h rd=%0d pc=%h adel=%b bad=%h",
                     nm, load_W, data_load_W, regaddr_W, pcout_W, adel_W, badaddr_W,
                     e.load, e.data, e.rd, e.pc, e.adel, e.bad);
        end
    endtask

    initial begin
        out_t z;
        out_t held;
        z = mk(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);

        // Reset, with stall and flush deliberately set to show reset dominates.
        add("reset0", 1, 0, 0, 1, 3'b000, 32'h4, 32'h1234, 32'h10, 5'd3, z);
        add("reset1", 1, 1, 1, 1, 3'b000, 32'h4, 32'h1234, 32'h10, 5'd3, z);

        // Main decode table.
        add("lb_off3",   0,0,0, 1, 3'b011, 32'h3,    32'h80FF0000, 32'h100, 5'd8,
            mk(1, 32'hFFFFFF80, 5'd8, 32'h100, 0, 32'h0));
        add("lhu_off2",  0,0,0, 1, 3'b010, 32'h2,    32'h9ABC1234, 32'h104, 5'd9,
            mk(1, 32'h00009ABC, 5'd9, 32'h104, 0, 32'h0));
        add("lh_off2",   0,0,0, 1, 3'b001, 32'h2,    32'h9ABC1234, 32'h108, 5'd9,
            mk(1, 32'hFFFF9ABC, 5'd9, 32'h108, 0, 32'h0));
        add("lw_mis",    0,0,0, 1, 3'b000, 32'h6,    32'h11223344, 32'h3010, 5'd10,
            mk(0, 32'h0, 5'd10, 32'h3010, 1, 32'h6));
        add("lw_oor",    0,0,0, 1, 3'b000, 32'h1000, 32'h11223344, 32'h3014, 5'd11,
            mk(0, 32'h0, 5'd11, 32'h3014, 1, 32'h1000));
        add("resv110",   0,0,0, 1, 3'b110, 32'h0,    32'hDEADBEEF, 32'h3018, 5'd12,
            mk(0, 32'h0, 5'd12, 32'h3018, 0, 32'h0));
        add("resv101",   0,0,0, 1, 3'b101, 32'h3,    32'hDEADBEEF, 32'h301C, 5'd12,
            mk(0, 32'h0, 5'd12, 32'h301C, 0, 32'h0));
        add("lbu_off1",  0,0,0, 1, 3'b100, 32'h1,    32'h12348756, 32'h200, 5'd3,
            mk(1, 32'h00000087, 5'd3, 32'h200, 0, 32'h0));
        add("lb_off0",   0,0,0, 1, 3'b011, 32'h0,    32'h0000007F, 32'h204, 5'd4,
            mk(1, 32'h0000007F, 5'd4, 32'h204, 0, 32'h0));
        add("lb_off2",   0,0,0, 1, 3'b011, 32'h2,    32'h00C30000, 32'h208, 5'd4,
            mk(1, 32'hFFFFFFC3, 5'd4, 32'h208, 0, 32'h0));
        add("lh_off0",   0,0,0, 1, 3'b001, 32'h0,    32'h00008001, 32'h20C, 5'd6,
            mk(1, 32'hFFFF8001, 5'd6, 32'h20C, 0, 32'h0));
        add("lh_mis",    0,0,0, 1, 3'b001, 32'h1,    32'h00008001, 32'h210, 5'd5,
            mk(0, 32'h0, 5'd5, 32'h210, 1, 32'h1));
        add("lhu_mis",   0,0,0, 1, 3'b010, 32'h3,    32'h00008001, 32'h214, 5'd5,
            mk(0, 32'h0, 5'd5, 32'h214, 1, 32'h3));
        add("adel_clr",  0,0,0, 1, 3'b000, 32'hFFC,  32'hCAFEBABE, 32'h218, 5'd31,
            mk(1, 32'hCAFEBABE, 5'd31, 32'h218, 0, 32'h0));
        add("rd0",       0,0,0, 1, 3'b000, 32'h8,    32'h12345678, 32'h21C, 5'd0,
            mk(0, 32'h0, 5'd0, 32'h21C, 0, 32'h0));
        add("rd0_err",   0,0,0, 1, 3'b000, 32'h6,    32'h12345678, 32'h220, 5'd0,
            mk(0, 32'h0, 5'd0, 32'h220, 1, 32'h6));
        add("noload",    0,0,0, 0, 3'b000, 32'h4,    32'h11111111, 32'h40, 5'd7,
            mk(0, 32'h0, 5'd7, 32'h40, 0, 32'h0));
        add("noload_bad",0,0,0, 0, 3'b000, 32'h2006, 32'h11111111, 32'h44, 5'd7,
            mk(0, 32'h0, 5'd7, 32'h44, 0, 32'h0));
        add("lbu_oor",   0,0,0, 1, 3'b100, 32'h2000, 32'h000000FF, 32'h48, 5'd2,
            mk(0, 32'h0, 5'd2, 32'h48, 1, 32'h2000));

        // Stall holds a valid lw while M inputs change; stall+flush bubbles.
        held = mk(1, 32'hA5A5A5A5, 5'd4, 32'h500, 0, 32'h0);
        add("cap_lw",    0,0,0, 1, 3'b000, 32'h10, 32'hA5A5A5A5, 32'h500, 5'd4, held);
        add("stall1",    0,1,0, 1, 3'b011, 32'h3,  32'h80000000, 32'h504, 5'd9, held);
        add("stall2",    0,1,0, 1, 3'b000, 32'h6,  32'h00000000, 32'h508, 5'd1, held);
        add("stall3",    0,1,0, 0, 3'b110, 32'h0,  32'hFFFFFFFF, 32'h50C, 5'd2, held);
        add("stl_flush", 0,1,1, 1, 3'b000, 32'h10, 32'h12345678, 32'h510, 5'd5, z);
        add("flush_err", 0,0,1, 1, 3'b000, 32'h6,  32'h12345678, 32'h514, 5'd5, z);
        add("stall_err", 0,0,0, 1, 3'b000, 32'h6,  32'h12345678, 32'h518, 5'd5,
            mk(0, 32'h0, 5'd5, 32'h518, 1, 32'h6));
        add("stall_adel",0,1,0, 1, 3'b000, 32'h0,  32'h12345678, 32'h51C, 5'd5,
            mk(0, 32'h0, 5'd5, 32'h518, 1, 32'h6));

        // Reset during a stall that is holding a valid load.
        add("cap_lw2",   0,0,0, 1, 3'b000, 32'h20, 32'h0BADF00D, 32'h600, 5'd6,
            mk(1, 32'h0BADF00D, 5'd6, 32'h600, 0, 32'h0));
        add("rst_stall", 1,1,0, 1, 3'b000, 32'h20, 32'h0BADF00D, 32'h604, 5'd6, z);
        add("post_rst",  0,0,0, 1, 3'b001, 32'h2,  32'h7FFF0000, 32'h608, 5'd7,
            mk(1, 32'h00007FFF, 5'd7, 32'h608, 0, 32'h0));

        foreach (vt[i]) begin
            reset      = vt[i].rst;
            stall      = vt[i].stl;
            flush      = vt[i].fl;
            load_M     = vt[i].ld;
            loadop_M   = vt[i].op;
            data_alu_M = vt[i].addr;
            data_dm_M  = vt[i].dm;
            pcout_M    = vt[i].pc;
            regaddr_M  = vt[i].rd;
            exp_q.push_back(vt[i].exp);
            @(posedge clk);
            #1;
            check(vt[i].name);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_load_stage.md
DM_LOAD_STAGE -- requirements
Module: dm_load_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous and active-high.
REQ-003 SHALL have port load_M, input, 1, load instruction valid in M stage.
REQ-004 SHALL have port loadop_M, input, 3, load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101-111 reserved.
REQ-005 SHALL have port data_alu_M, input, 32, byte address of the load.
REQ-006 SHALL have port data_dm_M, input, 32, raw word read from data memory at data_alu_M[11:2].
REQ-007 SHALL have port pcout_M, input, 32, PC of the M-stage instruction.
REQ-008 SHALL have port regaddr_M, input, 5, destination register of the load.
REQ-009 SHALL have port stall, input, 1, hold the W-stage register.
REQ-010 SHALL have port flush, input, 1, insert a bubble into W.
REQ-011 SHALL have port load_W, output, 1, register-write enable for the load result.
REQ-012 SHALL have port data_load_W, output, 32, aligned and extended load data.
REQ-013 SHALL have port regaddr_W, output, 5, destination register.
REQ-014 SHALL have port pcout_W, output, 32, PC of the W-stage instruction.
REQ-015 SHALL have port adel_W, output, 1, load address error flag.
REQ-016 SHALL have port badaddr_W, output, 32, faulting address; 0 when adel_W=0.

Function
REQ-017 SHALL register every M input on the rising clk edge; W outputs SHALL be valid one cycle after M capture (latency 1).
REQ-018 SHALL apply priority reset > flush > stall > capture on each edge.
REQ-019 SHALL, on stall=1 without flush, hold every output and every internal register unchanged.
REQ-020 SHALL, on flush=1, load a bubble: load_W=0, adel_W=0, data_load_W=0, regaddr_W=0, pcout_W=0, badaddr_W=0.
REQ-021 SHALL select byte lanes by data_alu_M[1:0]: offset 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-022 SHALL select halfword lanes: offset 0 -> [15:0], offset 2 -> [31:16].
REQ-023 SHALL sign-extend lb/lh and zero-extend lbu/lhu to 32 bits; lw passes the word unchanged.
REQ-024 SHALL flag misalignment: lw with data_alu_M[1:0]!=0, or lh/lhu with data_alu_M[0]=1.
REQ-025 SHALL flag out-of-range: data_alu_M[31:12]!=0 (4 KB memory).
REQ-026 SHALL, when load_M=1 and a flag per REQ-024/025 is raised, set adel_W=1, badaddr_W=data_alu_M, load_W=0 and data_load_W=0.
REQ-027 SHALL, for a reserved loadop_M, set load_W=0, data_load_W=0 and adel_W=0.
REQ-028 SHALL, when load_M=0, set load_W=0, adel_W=0, data_load_W=0, and pass regaddr_W and pcout_W through.
REQ-029 SHALL force data_load_W=0 and load_W=0 when regaddr_M=0.
REQ-030 SHALL clear adel_W on the next non-stalled capture without an error; there is no sticky state.

Reset
REQ-031 SHALL, with reset=1 at a rising edge, drive all outputs to 0 on that edge, regardless of stall and flush.
REQ-032 SHALL, on reset mid-stall, leave no held value after reset deasserts; the first capture follows normal rules.

Verification
REQ-033 Case 1: lb with addr 0x00000003 and data 0x80FF0000, regaddr 8 -> next cycle load_W=1, data_load_W=0xFFFFFF80, regaddr_W=8.
REQ-034 Case 2: lhu with addr 0x00000002 and data 0x9ABC1234 -> data_load_W=0x00009ABC; lh with the same inputs -> 0xFFFF9ABC.
REQ-035 Case 3: lw with addr 0x00000006, pc 0x00003010 -> adel_W=1, badaddr_W=0x00000006, load_W=0, pcout_W=0x00003010.
REQ-036 Case 4: a valid lw captured, then stall=1 for 3 cycles with the M inputs changing -> outputs constant; stall+flush asserted together -> bubble (all zero).
REQ-037 Case 5: lw with addr 0x00001000 -> adel_W=1 (out of range); a reserved op 110 -> load_W=0, adel_W=0.
REQ-038 Case 6: reset=1 while stall=1 with load_W=1 held -> all outputs 0 on that edge, then normal capture after reset deasserts.
